counter_ctrl: RTL

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_pkg.sv | 27 ++
 rtl/counter_ctrl_if.sv | 44 ++++
 rtl/counter_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter command controller.
// Holds the opcode and FSM state encodings plus width defaults.
// Optional saturation feature is selected with COUNTER_CTRL_SAT_EN.
package counter_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int STEP_W_DEF = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Command and counter-control bundle between a command issuer and counter_ctrl.
// Purely wiring: no latency of its own.
// Backpressure: cmd_ready_o from the controller gates cmd_valid_i; sat_o only with COUNTER_CTRL_SAT_EN.
interface counter_ctrl_if #(
    parameter int WIDTH  = counter_pkg::WIDTH_DEF,
    parameter int STEP_W = counter_pkg::STEP_W_DEF
);
    import counter_pkg::*;

    localparam int DW = max_w(WIDTH, STEP_W);

    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [DW-1:0] cmd_data_i;
    logic          load_o;
    logic [WIDTH-1:0] load_data_o;
    logic          en_o;
    logic          up_dn_o;
    logic          busy_o;
    logic          done_o;
`ifdef COUNTER_CTRL_SAT_EN
    logic          sat_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_data_i,
        input  cmd_ready_o, load_o, load_data_o, en_o, up_dn_o, busy_o, done_o, sat_o
    );
    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_data_i,
        output cmd_ready_o, load_o, load_data_o, en_o, up_dn_o, busy_o, done_o, sat_o
    );
`else
    modport master (
        output cmd_valid_i, cmd_op_i, cmd_data_i,
        input  cmd_ready_o, load_o, load_data_o, en_o, up_dn_o, busy_o, done_o
    );
    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_data_i,
        output cmd_ready_o, load_o, load_data_o, en_o, up_dn_o, busy_o, done_o
    );
`endif

endinterface

// File: rtl/counter_ctrl.sv
// Command FSM driving an external counter's load/enable/direction (optional COUNTER_CTRL_SAT_EN saturation).
// Latency: accept-to-done 2 cycles for LOAD/CLEAR, N+1 cycles for UP/DOWN (1 cycle when N==0).
// Backpressure: cmd_ready_o is high only in IDLE; commands are sampled on the accept cycle only.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    counter_ctrl_if.slave bus
);

    state_t            state, state_nxt;
    logic [STEP_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]  load_data_q, load_data_nxt;
    logic              load_q, en_q, up_q, up_nxt, busy_q, done_q;
    op_t               op;
    logic [STEP_W-1:0] step;

`ifdef COUNTER_CTRL_SAT_EN
    logic [WIDTH-1:0]  shadow, shadow_nxt;
    logic              sat_q, sat_nxt;

    // True when one more step in the given direction would wrap the counter.
    function automatic logic at_edge(input logic [WIDTH-1:0] v, input logic up);
        return up ? (v == '1) : (v == '0);
    endfunction
`endif

    assign op   = op_t'(bus.cmd_op_i);
    assign step = bus.cmd_data_i[STEP_W-1:0];

    assign bus.cmd_ready_o = (state == ST_IDLE);
    assign bus.load_o      = load_q;
    assign bus.load_data_o = load_data_q;
    assign bus.en_o        = en_q;
    assign bus.up_dn_o     = up_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

    // Next-state and next-register decode; outputs are registered from the next state.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        load_data_nxt = load_data_q;
        up_nxt        = up_q;
`ifdef COUNTER_CTRL_SAT_EN
        sat_nxt    = 1'b0;
        shadow_nxt = shadow;
        if (en_q) begin
            shadow_nxt = up_q ? shadow + WIDTH'(1) : shadow - WIDTH'(1);
        end
`endif
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    case (op)
                        OP_LOAD, OP_CLEAR: begin
                            state_nxt     = ST_LOAD;
                            load_data_nxt = (op == OP_LOAD) ? bus.cmd_data_i[WIDTH-1:0] : '0;
`ifdef COUNTER_CTRL_SAT_EN
                            shadow_nxt    = load_data_nxt;
`endif
                        end
                        default: begin
                            up_nxt  = (op == OP_UP);
                            cnt_nxt = step;
                            if (step == '0) begin
                                state_nxt = ST_DONE;
                            end
`ifdef COUNTER_CTRL_SAT_EN
                            else if (at_edge(shadow, up_nxt)) begin
                                state_nxt = ST_DONE;
                                sat_nxt   = 1'b1;
                            end
`endif
                            else begin
                                state_nxt = ST_RUN;
                            end
                        end
                    endcase
                end
            end
            ST_LOAD: state_nxt = ST_DONE;
            ST_RUN: begin
                cnt_nxt = cnt - STEP_W'(1);
                // The final requested step is in flight this cycle.
                if (cnt == STEP_W'(1)) begin
                    state_nxt = ST_DONE;
                end
`ifdef COUNTER_CTRL_SAT_EN
                else if (at_edge(shadow_nxt, up_q)) begin
                    state_nxt = ST_DONE;
                    sat_nxt   = 1'b1;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, step counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            load_q      <= 1'b0;
            load_data_q <= '0;
            en_q        <= 1'b0;
            up_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            load_q      <= (state_nxt == ST_LOAD);
            load_data_q <= load_data_nxt;
            en_q        <= (state_nxt == ST_RUN);
            up_q        <= up_nxt;
            busy_q      <= (state_nxt != ST_IDLE);
            done_q      <= (state_nxt == ST_DONE);
        end
    end

`ifdef COUNTER_CTRL_SAT_EN
    assign bus.sat_o = sat_q;

    // Shadow copy of the downstream counter and the saturation flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow <= '0;
            sat_q  <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            sat_q  <= sat_nxt;
        end
    end
`endif

endmodule
